// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mem_pkg
//  Description : Shared types and constants for the parametrised SPI memory
//                slave: FSM state encoding, command-word width helper and
//                the read/write flag value.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package spi_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        RD_LOAD = 3'd2,
        RD      = 3'd3,
        WR      = 3'd4,
        HOLD    = 3'd5
    } state_t;

    // Value of the trailing command bit that requests a read.
    localparam logic RW_READ = 1'b1;

    // Command word is the address followed by a single R/W bit.
    function automatic int cmd_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Multi-flop synchroniser for an asynchronous pin followed by
//                registered rise/fall detection. Edge pulses are one clk wide
//                and lag the pin by STAGES+1 clk; level lags by STAGES clk.
//  Ports       : clk, rst_n      - system clock, async active-low reset
//                pin_in          - asynchronous pin
//                level           - synchronised pin level
//                rise / fall     - single-cycle edge pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin_in};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/spi_mem_slave_param.sv
`default_nettype none
// ============================================================================
//  Module      : spi_mem_slave_param
//  Description : SPI mode-0 slave with an on-chip register-file memory.
//                Frame: ADDR_W address bits MSB first, one R/W bit
//                (1 = read), then DATA_W-bit data words.
//                Build option SPI_BURST_EN: when defined, reads and writes
//                continue with auto-incremented addresses until cs rises;
//                when undefined, one data word per frame, then HOLD.
//  Ports       : clk, rst_n              - system clock, async active-low reset
//                sclk_pin, cs_pin, mosi  - asynchronous SPI pins
//                miso_pin, miso_oe       - serial data out and its enable
//                leds                    - low nibble of last written word
//                busy                    - frame in progress
//                oor_err                 - sticky out-of-range access flag
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module spi_mem_slave_param
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic [3:0] leds,
    output logic       busy,
    output logic       oor_err
);

    localparam int C_CMD_W = cmd_width(ADDR_W);
    localparam int C_SH_W  = (C_CMD_W > DATA_W) ? C_CMD_W : DATA_W;
    localparam int C_CNT_W = $clog2(C_SH_W + 1);
    localparam int C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [C_CNT_W-1:0] C_CMD_LAST  = C_CNT_W'(C_CMD_W - 1);
    localparam logic [C_CNT_W-1:0] C_DATA_LAST = C_CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0]    C_DEPTH     = (ADDR_W + 1)'(DEPTH);

    // ---------------------------------------------------------------- pins
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi;
    logic w_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (sclk_pin),
        .level  (w_sclk_level),
        .rise   (w_sclk_rise),
        .fall   (w_sclk_fall)
    );

    // cs idles high, so its synchroniser resets high to avoid a phantom edge.
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_in (cs_pin),
        .level  (w_cs_level),
        .rise   (w_cs_rise),
        .fall   (w_cs_fall)
    );

    // Abort is taken from the cs level, so the rise pulse and SCLK level
    // are not needed.
    assign w_unused = &{1'b0, w_sclk_level, w_cs_rise};

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
    assign w_mosi      = mosi_sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------- state
    state_t              state_q, state_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    // Holds all but the newest bit; the newest comes straight from w_mosi.
    logic [C_SH_W-2:0]   shift_q, shift_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                miso_q, miso_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic [3:0]          leds_q, leds_d;
    logic                oor_q, oor_d;

    // ------------------------------------------------------------- memory
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [C_IDX_W-1:0]  w_mem_idx;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_rx_word;
    logic [C_SH_W-2:0]   w_shift_in;
    logic                w_mem_we;

    assign w_in_range = ({1'b0, addr_q} < C_DEPTH);
    assign w_mem_idx  = addr_q[C_IDX_W-1:0];
    assign w_rdata    = w_in_range ? mem[w_mem_idx] : '0;
    assign w_rx_word  = {shift_q[DATA_W-2:0], w_mosi};
    assign w_shift_in = {shift_q[C_SH_W-3:0], w_mosi};

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_idx] <= w_rx_word;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        miso_d   = miso_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        leds_d   = leds_q;
        oor_d    = oor_q;
        w_mem_we = 1'b0;

        if ((state_q != IDLE) && w_cs_level) begin
            // cs deasserted: abandon the frame, partial words are dropped.
            state_d = IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        miso_d  = 1'b0;
                        oe_d    = 1'b0;
                    end
                end

                CMD: begin
                    if (w_sclk_rise) begin
                        shift_d = w_shift_in;
                        if (cnt_q == C_CMD_LAST) begin
                            cnt_d   = '0;
                            addr_d  = shift_q[ADDR_W-1:0];
                            state_d = (w_mosi == RW_READ) ? RD_LOAD : WR;
                        end else begin
                            cnt_d = cnt_q + C_CNT_W'(1);
                        end
                    end
                end

                RD_LOAD: begin
                    miso_d                = w_rdata[DATA_W-1];
                    shift_d               = '0;
                    shift_d[DATA_W-2:0]   = w_rdata[DATA_W-2:0];
                    oe_d                  = 1'b1;
                    state_d               = RD;
                    if (!w_in_range) begin
                        oor_d = 1'b1;
                    end
                end

                RD: begin
                    // Bits are counted on rises (master samples there); the
                    // fall following a word's last rise must not shift, which
                    // is why a zero count blocks the shift.
                    if (w_sclk_rise) begin
                        if (cnt_q == C_DATA_LAST) begin
                            cnt_d = '0;
`ifdef SPI_BURST_EN
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = RD_LOAD;
`else
                            miso_d  = 1'b0;
                            state_d = HOLD;
`endif
                        end else begin
                            cnt_d = cnt_q + C_CNT_W'(1);
                        end
                    end else if (w_sclk_fall && (cnt_q != '0)) begin
                        miso_d  = shift_q[DATA_W-2];
                        shift_d = {shift_q[C_SH_W-3:0], 1'b0};
                    end
                end

                WR: begin
                    if (w_sclk_rise) begin
                        shift_d = w_shift_in;
                        if (cnt_q == C_DATA_LAST) begin
                            cnt_d = '0;
                            if (w_in_range) begin
                                w_mem_we = 1'b1;
                                leds_d   = w_rx_word[3:0];
                            end else begin
                                oor_d = 1'b1;
                            end
`ifdef SPI_BURST_EN
                            addr_d = addr_q + ADDR_W'(1);
`else
                            state_d = HOLD;
`endif
                        end else begin
                            cnt_d = cnt_q + C_CNT_W'(1);
                        end
                    end
                end

                HOLD: begin
                    // Wait for cs to rise; SCLK is ignored.
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            leds_q      <= 4'h0;
            oor_q       <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            leds_q      <= leds_d;
            oor_q       <= oor_d;
        end
    end

    assign miso_pin = miso_q;
    assign miso_oe  = oe_q;
    assign leds     = leds_q;
    assign busy     = busy_q;
    assign oor_err  = oor_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_slave_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_mem_slave_param
//  Description : Self-checking bench for spi_mem_slave_param (DEPTH=100).
//                A mode-0 SPI master drives frames; expected values come from
//                a word-level memory model of the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_slave_param;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 100;
    localparam int SYNC   = 2;
    localparam int HALF   = 80;     // half SCLK period = 8 clk
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       miso_pin;
    logic       miso_oe;
    logic [3:0] leds;
    logic       busy;
    logic       oor_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spi_mem_slave_param #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin),
        .miso_oe  (miso_oe),
        .leds     (leds),
        .busy     (busy),
        .oor_err  (oor_err)
    );

    // ------------------------------------------------ reference model
    logic [7:0] m_mem   [128];
    bit         m_valid [128];
    logic [3:0] m_leds = 4'h0;
    logic       m_oor  = 1'b0;

    task automatic m_write_frame(input int a, input int n, input logic [31:0] d);
        int aa = a;
        for (int i = 0; i < n; i++) begin
            if (!BURST && i > 0) break;
            if (aa < DEPTH) begin
                m_mem[aa]   = d[8*i +: 8];
                m_valid[aa] = 1'b1;
                m_leds      = d[8*i +: 4];
            end else begin
                m_oor = 1'b1;
            end
            aa = (aa + 1) % 128;
        end
    endtask

    // Fills expected words and a per-word "known" mask.
    task automatic m_read_frame(input int a, input int n,
                                output logic [31:0] exp, output logic [3:0] known);
        int aa = a;
        exp   = '0;
        known = '0;
        for (int i = 0; i < n; i++) begin
            if (!BURST && i > 0) begin
                known[i] = 1'b1;        // HOLD drives zeros
            end else if (aa >= DEPTH) begin
                known[i] = 1'b1;
                m_oor    = 1'b1;
            end else begin
                exp[8*i +: 8] = m_mem[aa];
                known[i]      = m_valid[aa];
            end
            aa = (aa + 1) % 128;
        end
    endtask

    // ------------------------------------------------ SPI master
    task automatic spi_bit(input logic b, output logic s_miso,
                           output logic s_oe, output logic s_busy);
        mosi_pin = b;
        #(HALF);
        s_miso   = miso_pin;
        s_oe     = miso_oe;
        s_busy   = busy;
        sclk_pin = 1'b1;
        #(HALF);
        sclk_pin = 1'b0;
    endtask

    task automatic spi_start();
        @(negedge clk);
        sclk_pin = 1'b0;
        cs_pin   = 1'b0;
        #(HALF);
    endtask

    task automatic spi_cmd(input logic [6:0] a, input logic rw);
        logic s0, s1, s2;
        for (int i = ADDR_W - 1; i >= 0; i--) spi_bit(a[i], s0, s1, s2);
        spi_bit(rw, s0, s1, s2);
    endtask

    task automatic spi_words(input int nbits, input logic [31:0] wd,
                             output logic [31:0] rd, output logic oe0,
                             output logic busy0);
        logic s, so, sb;
        rd    = '0;
        oe0   = 1'b0;
        busy0 = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(wd[8*(i/8) + 7 - (i%8)], s, so, sb);
            rd[8*(i/8) + 7 - (i%8)] = s;
            if (i == 0) begin
                oe0   = so;
                busy0 = sb;
            end
        end
    endtask

    task automatic spi_end();
        #(HALF);
        cs_pin   = 1'b1;
        mosi_pin = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_write(input logic [6:0] a, input int n, input logic [31:0] d);
        logic [31:0] rd;
        logic oe0, b0;
        spi_start();
        spi_cmd(a, 1'b0);
        spi_words(8*n, d, rd, oe0, b0);
        spi_end();
        m_write_frame(int'(a), n, d);
    endtask

    task automatic do_read(input logic [6:0] a, input int n,
                           output logic [31:0] rd, output logic oe0, output logic b0);
        spi_start();
        spi_cmd(a, 1'b1);
        spi_words(8*n, 32'h0, rd, oe0, b0);
        spi_end();
    endtask

    // ------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0; sclk_pin = 1'b0; cs_pin = 1'b1; mosi_pin = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (miso_pin !== 1'b0) $display("FAIL reset_miso got %b exp 0", miso_pin); else n_pass++;
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL reset_oe got %b exp 0", miso_oe); else n_pass++;
        n_checks++; if (leds !== 4'h0) $display("FAIL reset_leds got %h exp 0", leds); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (oor_err !== 1'b0) $display("FAIL reset_oor got %b exp 0", oor_err); else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, exp;
        logic [3:0]  kn;
        logic oe0, b0;
        do_write(7'h61, 1, 32'hB1);
        n_checks++; if (leds !== m_leds) $display("FAIL wr_leds got %h exp %h", leds, m_leds); else n_pass++;
        n_checks++; if (oor_err !== 1'b0) $display("FAIL wr_oor got %b exp 0", oor_err); else n_pass++;
        do_read(7'h61, 1, rd, oe0, b0);
        m_read_frame(32'h61, 1, exp, kn);
        n_checks++; if (rd[7:0] !== 8'b1011_0001) $display("FAIL rd_61 got %h exp b1", rd[7:0]); else n_pass++;
        n_checks++; if (rd[7:0] !== exp[7:0]) $display("FAIL rd_61_model got %h exp %h", rd[7:0], exp[7:0]); else n_pass++;
        n_checks++; if (oe0 !== 1'b1) $display("FAIL rd_oe got %b exp 1", oe0); else n_pass++;
        n_checks++; if (b0 !== 1'b1) $display("FAIL rd_busy got %b exp 1", b0); else n_pass++;
        n_checks++; if (miso_oe !== 1'b0 || busy !== 1'b0)
            $display("FAIL post_frame_idle got oe=%b busy=%b exp 0 0", miso_oe, busy); else n_pass++;
    endtask

    task automatic test_oor();
        logic [31:0] rd, exp;
        logic [3:0]  kn;
        logic oe0, b0;
        do_write(7'h70, 1, 32'hAA);
        n_checks++; if (oor_err !== 1'b1) $display("FAIL oor_wr got %b exp 1", oor_err); else n_pass++;
        do_read(7'h70, 1, rd, oe0, b0);
        m_read_frame(32'h70, 1, exp, kn);
        n_checks++; if (rd[7:0] !== 8'h00) $display("FAIL oor_rd got %h exp 00", rd[7:0]); else n_pass++;
        do_write(7'h02, 1, 32'h4D);
        n_checks++; if (oor_err !== m_oor) $display("FAIL oor_sticky got %b exp %b", oor_err, m_oor); else n_pass++;
        n_checks++; if (leds !== m_leds) $display("FAIL oor_leds got %h exp %h", leds, m_leds); else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp;
        logic [3:0]  kn;
        logic oe0, b0;
        do_write(7'h10, 1, 32'h3C);
        spi_start();
        spi_cmd(7'h10, 1'b0);
        spi_words(5, 32'hFF, rd, oe0, b0);
        #(HALF);
        cs_pin = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL abort_oe got %b exp 0", miso_oe); else n_pass++;
        repeat (6) @(negedge clk);
        do_read(7'h10, 1, rd, oe0, b0);
        m_read_frame(32'h10, 1, exp, kn);
        n_checks++; if (rd[7:0] !== exp[7:0]) $display("FAIL abort_mem got %h exp %h", rd[7:0], exp[7:0]); else n_pass++;
        n_checks++; if (leds !== m_leds) $display("FAIL abort_leds got %h exp %h", leds, m_leds); else n_pass++;
    endtask

    task automatic test_frame_words();
        logic [31:0] rd, exp;
        logic [3:0]  kn;
        logic oe0, b0;
`ifdef SPI_BURST_EN
        do_write(7'h7E, 3, 32'h00_33_22_11);
        do_read(7'h7E, 3, rd, oe0, b0);
        m_read_frame(32'h7E, 3, exp, kn);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (rd[8*i +: 8] !== exp[8*i +: 8])
                $display("FAIL burst_wrap_w%0d got %h exp %h", i, rd[8*i +: 8], exp[8*i +: 8]); else n_pass++;
        end
        do_write(7'h20, 4, 32'hA4_93_82_71);
        do_read(7'h20, 4, rd, oe0, b0);
        m_read_frame(32'h20, 4, exp, kn);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rd[8*i +: 8] !== exp[8*i +: 8])
                $display("FAIL burst_w%0d got %h exp %h", i, rd[8*i +: 8], exp[8*i +: 8]); else n_pass++;
        end
`else
        do_write(7'h06, 1, 32'h5A);
        do_write(7'h05, 2, 32'h96_C3);
        n_checks++; if (leds !== m_leds) $display("FAIL single_leds got %h exp %h", leds, m_leds); else n_pass++;
        do_read(7'h05, 2, rd, oe0, b0);
        m_read_frame(32'h05, 2, exp, kn);
        n_checks++; if (rd[7:0] !== exp[7:0]) $display("FAIL single_w0 got %h exp %h", rd[7:0], exp[7:0]); else n_pass++;
        n_checks++; if (rd[15:8] !== exp[15:8]) $display("FAIL single_hold got %h exp %h", rd[15:8], exp[15:8]); else n_pass++;
        do_read(7'h06, 1, rd, oe0, b0);
        m_read_frame(32'h06, 1, exp, kn);
        n_checks++; if (rd[7:0] !== exp[7:0]) $display("FAIL single_next got %h exp %h", rd[7:0], exp[7:0]); else n_pass++;
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, wd;
        logic [3:0]  kn;
        logic oe0, b0;
        logic [6:0]  a;
        int n;
        for (int it = 0; it < 8; it++) begin
            a  = 7'($urandom_range(0, 127));
            n  = BURST ? int'($urandom_range(1, 3)) : 1;
            wd = $urandom;
            do_write(a, n, wd);
            n_checks++; if (leds !== m_leds) $display("FAIL rnd_leds a=%h got %h exp %h", a, leds, m_leds); else n_pass++;
            do_read(a, n, rd, oe0, b0);
            m_read_frame(int'(a), n, exp, kn);
            n_checks++; if (oor_err !== m_oor) $display("FAIL rnd_oor a=%h got %b exp %b", a, oor_err, m_oor); else n_pass++;
            for (int i = 0; i < n; i++) begin
                if (kn[i]) begin
                    n_checks++; if (rd[8*i +: 8] !== exp[8*i +: 8])
                        $display("FAIL rnd_rd a=%h w%0d got %h exp %h", a, i, rd[8*i +: 8], exp[8*i +: 8]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd, exp;
        logic [3:0]  kn;
        logic oe0, b0;
        do_write(7'h33, 1, 32'h7B);
        spi_start();
        spi_cmd(7'h33, 1'b1);
        spi_words(3, 32'h0, rd, oe0, b0);
        n_checks++; if (oe0 !== 1'b1) $display("FAIL arst_pre_oe got %b exp 1", oe0); else n_pass++;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (miso_pin !== 1'b0) $display("FAIL arst_miso got %b exp 0", miso_pin); else n_pass++;
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL arst_oe got %b exp 0", miso_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (oor_err !== 1'b0) $display("FAIL arst_oor got %b exp 0", oor_err); else n_pass++;
        m_oor  = 1'b0;
        m_leds = 4'h0;
        cs_pin = 1'b1; sclk_pin = 1'b0; mosi_pin = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_write(7'h44, 1, 32'hE7);
        n_checks++; if (leds !== m_leds) $display("FAIL arst_leds got %h exp %h", leds, m_leds); else n_pass++;
        do_read(7'h44, 1, rd, oe0, b0);
        m_read_frame(32'h44, 1, exp, kn);
        n_checks++; if (rd[7:0] !== exp[7:0]) $display("FAIL arst_rd44 got %h exp %h", rd[7:0], exp[7:0]); else n_pass++;
        do_read(7'h33, 1, rd, oe0, b0);
        m_read_frame(32'h33, 1, exp, kn);
        n_checks++; if (rd[7:0] !== exp[7:0]) $display("FAIL arst_rd33 got %h exp %h", rd[7:0], exp[7:0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_oor();
        test_abort();
        test_frame_words();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
